// File: rtl/agu.sv
// ---------------------------------------------------------------------------
// agu - address generation unit for the RV32I core.
//
// Holds the program counter and selects the next fetch address from the
// sequential, PC-relative (conditional branch / JAL) and JALR targets.
//
// Ports
//   CLK        in   1   system clock, rising edge
//   _Rest      in   1   synchronous active-high reset (loads RESET_ADDR)
//   PCWre      in   1   PC write enable
//   PCSrc      in   2   00 seq, 01 cond branch, 10 JAL, 11 JALR
//   Taken      in   1   branch condition, only used for PCSrc=01
//   Imm        in  32   sign-extended, pre-scaled immediate
//   Rs1Data    in  32   rs1 operand for JALR
//   address    out 32   registered PC / instruction fetch address
//   PCPlus4    out 32   address + 4 (link value)
//   NextPC     out 32   candidate next PC
//   Misaligned out  1   NextPC not word aligned
// ---------------------------------------------------------------------------
module agu #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        _Rest,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        Taken,
    input  logic [31:0] Imm,
    input  logic [31:0] Rs1Data,
    output logic [31:0] address,
    output logic [31:0] PCPlus4,
    output logic [31:0] NextPC,
    output logic        Misaligned
);

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JAL  = 2'b10;
    localparam logic [1:0] SRC_JALR = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] w_seq;
    logic [31:0] w_rel;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_jalr;
    logic [31:0] w_next;
    logic        w_mis;

    // All adders are 32-bit; carries out are intentionally dropped.
    assign w_seq      = r_pc + 32'd4;
    assign w_rel      = r_pc + Imm;
    assign w_jalr_sum = Rs1Data + Imm;
    assign w_jalr     = {w_jalr_sum[31:1], 1'b0};

    always_comb begin
        w_next = w_seq;
        unique case (PCSrc)
            SRC_SEQ:  w_next = w_seq;
            SRC_BR:   w_next = Taken ? w_rel : w_seq;
            SRC_JAL:  w_next = w_rel;
            SRC_JALR: w_next = w_jalr;
            default:  w_next = w_seq;
        endcase
    end

    assign w_mis = w_next[1] | w_next[0];

    // Reset wins over PCWre. A misaligned target is never committed; the
    // control unit traps on Misaligned while the PC stays put.
    always_ff @(posedge CLK) begin
        if (_Rest) begin
            r_pc <= RESET_ADDR;
        end else if (PCWre && !w_mis) begin
            r_pc <= w_next;
        end
    end

    assign address    = r_pc;
    assign PCPlus4    = w_seq;
    assign NextPC     = w_next;
    assign Misaligned = w_mis;

endmodule

// File: tb/tb_agu.sv
module tb_agu;

    logic        CLK = 1'b0;
    logic        _Rest;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        Taken;
    logic [31:0] Imm;
    logic [31:0] Rs1Data;
    logic [31:0] address, PCPlus4, NextPC;
    logic        Misaligned;
    logic [31:0] address_b, PCPlus4_b, NextPC_b;
    logic        Misaligned_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    agu dut (
        .CLK(CLK), ._Rest(_Rest), .PCWre(PCWre), .PCSrc(PCSrc), .Taken(Taken),
        .Imm(Imm), .Rs1Data(Rs1Data), .address(address), .PCPlus4(PCPlus4),
        .NextPC(NextPC), .Misaligned(Misaligned)
    );

    agu #(.RESET_ADDR(32'h8000_0000)) dut_b (
        .CLK(CLK), ._Rest(_Rest), .PCWre(PCWre), .PCSrc(PCSrc), .Taken(Taken),
        .Imm(Imm), .Rs1Data(Rs1Data), .address(address_b), .PCPlus4(PCPlus4_b),
        .NextPC(NextPC_b), .Misaligned(Misaligned_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Force the PC to an aligned value via JALR with Imm=0.
    task automatic load_pc(input logic [31:0] pc);
        PCWre = 1'b1; PCSrc = 2'b11; Rs1Data = pc; Imm = 32'h0; Taken = 1'b0;
        tick();
    endtask

    logic [31:0] seq_exp [9];
    logic        seq_we  [9];

    initial begin
        seq_we  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        seq_exp = '{32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC, 32'h10, 32'h10, 32'h14};

        _Rest = 1'b1; PCWre = 1'b1; PCSrc = 2'b00; Taken = 1'b0;
        Imm = 32'h0; Rs1Data = 32'h0;
        #2;
        tick();
        chk("reset_addr", address, 32'h0);
        chk("reset_plus4", PCPlus4, 32'h4);
        chk("reset_addr_b", address_b, 32'h8000_0000);

        // Sequential run with PCWre alternating.
        _Rest = 1'b0; PCSrc = 2'b00;
        for (int i = 0; i < 9; i++) begin
            PCWre = seq_we[i];
            tick();
            chk($sformatf("seq_addr%0d", i), address, seq_exp[i]);
            chk($sformatf("seq_plus4_%0d", i), PCPlus4, seq_exp[i] + 32'd4);
        end

        // Conditional branch taken / not taken from 0x100.
        load_pc(32'h100);
        chk("load_100", address, 32'h100);
        PCSrc = 2'b01; Imm = 32'hFFFF_FFF0; Taken = 1'b1; #1;
        chk("br_t_next", NextPC, 32'hF0);
        tick();
        chk("br_t_addr", address, 32'hF0);
        load_pc(32'h100);
        PCSrc = 2'b01; Imm = 32'hFFFF_FFF0; Taken = 1'b0; #1;
        chk("br_nt_next", NextPC, 32'h104);
        tick();
        chk("br_nt_addr", address, 32'h104);

        // JAL then JALR (Taken set high to show it is ignored).
        load_pc(32'h200);
        PCSrc = 2'b10; Imm = 32'h800; Taken = 1'b1; #1;
        chk("jal_plus4", PCPlus4, 32'h204);
        chk("jal_next", NextPC, 32'hA00);
        tick();
        chk("jal_addr", address, 32'hA00);
        PCSrc = 2'b11; Rs1Data = 32'h1235; Imm = 32'h10; #1;
        chk("jalr_next", NextPC, 32'h1244);
        chk("jalr_mis", {31'b0, Misaligned}, 32'h0);
        tick();
        chk("jalr_addr", address, 32'h1244);

        // Misaligned targets do not commit.
        load_pc(32'h300);
        PCSrc = 2'b10; Imm = 32'h6; Taken = 1'b0; PCWre = 1'b1; #1;
        chk("mis_jal_flag", {31'b0, Misaligned}, 32'h1);
        tick();
        chk("mis_jal_hold", address, 32'h300);
        PCSrc = 2'b11; Rs1Data = 32'h3; Imm = 32'h0; #1;
        chk("mis_jalr_next", NextPC, 32'h2);
        chk("mis_jalr_flag", {31'b0, Misaligned}, 32'h1);
        tick();
        chk("mis_jalr_hold", address, 32'h300);

        // PCWre=0 holds even with a valid target.
        PCSrc = 2'b10; Imm = 32'h40; PCWre = 1'b0;
        tick();
        chk("we0_hold", address, 32'h300);

        // Wrap-around.
        load_pc(32'hFFFF_FFFC);
        PCSrc = 2'b00; #1;
        chk("wrap_next", NextPC, 32'h0);
        chk("wrap_mis", {31'b0, Misaligned}, 32'h0);
        tick();
        chk("wrap_addr", address, 32'h0);

        // Reset has priority over a pending enabled update.
        load_pc(32'h40);
        PCSrc = 2'b10; Imm = 32'h100; PCWre = 1'b1; _Rest = 1'b1;
        tick();
        chk("rst_prio", address, 32'h0);
        chk("rst_prio_b", address_b, 32'h8000_0000);
        _Rest = 1'b0; PCSrc = 2'b00;
        tick();
        chk("post_rst", address, 32'h4);
        chk("post_rst_b", address_b, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/agu.md
# agu

Address generation unit for the RV32I core: holds the program counter and computes the next fetch address. It supports sequential, conditional-branch, JAL and JALR targets. The block sits between decode/execute and the instruction memory. `address` drives the instruction-fetch port, and the control unit's `PCWre` strobe gates every PC update.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `_Rest`  in  1  reset, synchronous, active-high (despite the leading underscore).
- `PCWre`  in  1  PC write enable; PC updates only on edges where it is 1.
- `PCSrc`  in  2  next-PC select: 00 sequential, 01 conditional branch, 10 JAL, 11 JALR.
- `Taken`  in  1  branch condition from the ALU; used only when `PCSrc`=01.
- `Imm`  in  32  sign-extended immediate (B/J/I-type, already scaled).
- `Rs1Data`  in  32  rs1 operand for JALR.
- `address`  out  32  current PC, registered; the instruction fetch address.
- `PCPlus4`  out  32  `address`+4, combinational; the link value for JAL/JALR.
- `NextPC`  out  32  candidate next PC, combinational.
- `Misaligned`  out  1  combinational; 1 when `NextPC[1:0]` != 0.

## Operation
- Sequential target = `address` + 4.
- Relative target = `address` + `Imm`.
- JALR target = (`Rs1Data` + `Imm`) with bit 0 forced to 0.
- All arithmetic is 32-bit modulo 2^32; carries out are discarded.
- `NextPC` selection by `PCSrc`:
  - 00: sequential target.
  - 01: relative target if `Taken`=1, otherwise sequential target.
  - 10: relative target.
  - 11: JALR target.
- `Misaligned` = `NextPC[1]` | `NextPC[0]`. After JALR masking, only bit 1 can cause it.
- When `PCWre`=1, `Misaligned`=0 and reset is inactive, `address` <= `NextPC` at the edge.
- When `PCWre`=1 and `Misaligned`=1, `address` holds its value. The control unit raises the exception from the `Misaligned` flag.
- When `PCWre`=0, `address` holds its value regardless of the other inputs.
- `PCPlus4` always reflects the current `address`, not `NextPC`.

## Timing
- Reset: on a rising edge with `_Rest`=1, `address` <= `RESET_ADDR`.
  - Reset has priority over `PCWre`.
  - With the default parameter, `PCPlus4` = 0x4 while reset holds.
- Latency: `NextPC` and `Misaligned` follow their inputs in the same cycle. `address` takes the new value one edge after the enabled update.
- No handshake. One update per enabled edge. There is no pipeline and no internal state besides the PC register.
- Wrap-around: `address`=0xFFFF_FFFC with a sequential update gives 0x0000_0000, with no flag.
- Reset mid-operation: reset on any edge discards the pending update. The first enabled edge after reset computes from `RESET_ADDR`.
- Simultaneous events:
  - `_Rest`=1 with `PCWre`=1 gives `address`=`RESET_ADDR`.
  - `Taken` is ignored for `PCSrc` ∈ {00, 10, 11}.

## Test plan
- Reset then sequential run:
  - Hold `_Rest`=1 for one edge, giving `address`=0x0.
  - Then `_Rest`=0, `PCSrc`=00, and `PCWre` alternating 1/0 each edge (1,0,1,0,1,0,1,0,1).
  - Required: `address` steps 0x0 → 0x4 (hold) → 0x8 (hold) → 0xC (hold) → 0x10 (hold) → 0x14.
  - Required: `PCPlus4` is always `address`+4.
- Conditional branch:
  - Start at `address`=0x100 with `PCSrc`=01 and `Imm`=0xFFFF_FFF0 (−16).
  - `Taken`=1 → next `address`=0xF0.
  - Repeat from 0x100 with `Taken`=0 → 0x104.
- JAL and JALR:
  - From 0x200, `PCSrc`=10, `Imm`=0x800 → 0xA00, with `PCPlus4`=0x204 before the edge.
  - `PCSrc`=11, `Rs1Data`=0x1235, `Imm`=0x10 → 0x1244 (bit 0 cleared).
- Misaligned target:
  - From 0x300, `PCSrc`=10, `Imm`=0x6, `PCWre`=1 → `Misaligned`=1 and `address` stays 0x300.
  - `PCSrc`=11, `Rs1Data`=0x3, `Imm`=0 → target 0x2, so `Misaligned`=1.
- Wrap and reset priority:
  - From 0xFFFF_FFFC with a sequential update → 0x0.
  - Then `_Rest`=1 and `PCWre`=1 together on one edge → `address`=`RESET_ADDR`.
  - Repeat with `RESET_ADDR`=0x8000_0000 → `address`=0x8000_0000.
